// File: rtl/pid_pkg.sv
// pid_pkg: shared state codes, widths and saturation limits for the PID sequencer.
package pid_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PMUL = 2'd1;
    localparam logic [1:0] DMUL = 2'd2;
    localparam logic [1:0] SUM  = 2'd3;

    localparam int ERR_W   = 16;
    localparam int SAT_W   = 11;
    localparam int COEFF_W = 6;
    localparam int PROD_W  = 17;
    localparam int TERM_W  = 16;
    localparam int ITERM_W = 10;
    localparam int SPD_W   = 12;

    localparam logic signed [SAT_W-1:0] SAT11_MAX = 11'sh3FF;
    localparam logic signed [SAT_W-1:0] SAT11_MIN = 11'sh400;
    localparam logic signed [SPD_W-1:0] SAT12_MAX = 12'sh7FF;
    localparam logic signed [SPD_W-1:0] SAT12_MIN = 12'sh800;

    function automatic logic signed [SPD_W-1:0] sat12(input logic signed [13:0] v);
        return (v > 14'sd2047) ? SAT12_MAX : (v < -14'sd2048) ? SAT12_MIN : v[SPD_W-1:0];
    endfunction
endpackage

// File: rtl/pid_mult.sv
// pid_mult: the single shared signed 11x6 multiplier of the PID sequencer.
module pid_mult
    import pid_pkg::*;
(
    input  logic signed [SAT_W-1:0]   a,
    input  logic signed [COEFF_W-1:0] b,
    output logic signed [PROD_W-1:0]  p
);
    assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/pid_sequencer.sv
// pid_sequencer: one PID update per error sample, P and D time-shared on one multiplier,
// mixed with the base speed into saturated left/right motor speeds.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter logic signed [COEFF_W-1:0] P_COEFF   = 6'sd3,
    parameter logic signed [COEFF_W-1:0] D_COEFF   = 6'sd7,
    parameter int                        PID_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ERR_W-1:0]   error,
    input  logic                      error_vld,
    input  logic                      go,
    input  logic [SAT_W-1:0]          frwrd_spd,
    input  logic signed [ITERM_W-1:0] I_term,
    output logic signed [SAT_W-1:0]   err_sat,
    output logic                      err_vld,
    output logic signed [SPD_W-1:0]   lft_spd,
    output logic signed [SPD_W-1:0]   rght_spd,
    output logic                      pid_vld,
    output logic                      busy,
    output logic                      ovr
);
    logic [1:0]                 state;
    logic signed [SAT_W-1:0]    prev_err, err_cap, mul_a;
    logic signed [COEFF_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]   prod, pid;
    logic signed [TERM_W-1:0]   p_term, d_term;
    logic signed [11:0]         d_full;
    logic signed [7:0]          d_sat;
    logic signed [13:0]         pid_sh;
    logic signed [SPD_W-1:0]    adj;
    logic signed [12:0]         base, lft_sum, rght_sum;

    assign err_cap = (error > 16'sd1023) ? SAT11_MAX : (error < -16'sd1024) ? SAT11_MIN : error[SAT_W-1:0];
    assign d_full  = 12'(err_sat) - 12'(prev_err);
    assign d_sat   = (d_full > 12'sd127) ? 8'sd127 : (d_full < -12'sd128) ? 8'sh80 : d_full[7:0];

    // Operands are forced to zero outside the multiply states so the multiplier stays quiet.
    assign mul_a = (state == PMUL) ? err_sat : (state == DMUL) ? SAT_W'(d_sat) : '0;
    assign mul_b = (state == PMUL) ? P_COEFF : (state == DMUL) ? D_COEFF : '0;

    pid_mult u_mult (.a(mul_a), .b(mul_b), .p(prod));

    assign pid      = PROD_W'(p_term) + PROD_W'(d_term) + PROD_W'(I_term);
    assign pid_sh   = 14'(pid >>> PID_SHIFT);
    assign adj      = sat12(pid_sh);
    assign base     = 13'($signed({1'b0, frwrd_spd}));
    assign lft_sum  = base + 13'(adj);
    assign rght_sum = base - 13'(adj);

    assign err_vld = (state == PMUL);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_sat  <= '0;
            prev_err <= '0;
            p_term   <= '0;
            d_term   <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            pid_vld  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            ovr     <= error_vld && (state != IDLE);
            pid_vld <= 1'b0;
            if (!go) begin
                state    <= IDLE;
                prev_err <= '0;
                lft_spd  <= '0;
                rght_spd <= '0;
            end else begin
                case (state)
                    IDLE: if (error_vld) begin
                        err_sat <= err_cap;
                        state   <= PMUL;
                    end
                    PMUL: begin
                        p_term <= TERM_W'(prod);
                        state  <= DMUL;
                    end
                    DMUL: begin
                        d_term <= TERM_W'(prod);
                        state  <= SUM;
                    end
                    default: begin
                        lft_spd  <= sat12(14'(lft_sum));
                        rght_spd <= sat12(14'(rght_sum));
                        prev_err <= err_sat;
                        pid_vld  <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pid_sequencer.sv
// tb_pid_sequencer: directed and randomized checks of pid_sequencer against an integer model.
module tb_pid_sequencer;
    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] error;
    logic               error_vld, go;
    logic [10:0]        frwrd_spd;
    logic signed [9:0]  I_term;
    logic signed [10:0] err_sat;
    logic               err_vld, pid_vld, busy, ovr;
    logic signed [11:0] lft_spd, rght_spd;

    pid_sequencer dut (
        .clk(clk), .rst_n(rst_n), .error(error), .error_vld(error_vld), .go(go),
        .frwrd_spd(frwrd_spd), .I_term(I_term), .err_sat(err_sat), .err_vld(err_vld),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .pid_vld(pid_vld), .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int m_prev  = 0;
    int obs_lat, obs_vld_cnt, obs_evld_cnt, obs_ovr_cnt;
    logic        obs_evld0;
    logic [10:0] obs_err_sat;
    logic [8:0]  obs_busy;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Reference: plain integer arithmetic over the gains 3 and 7 and a divide-by-8 floor.
    task automatic model(input int e, input int fw, input int it, output int es, output int el, output int er);
        int d, pid, adj;
        es  = clamp(e, -1024, 1023);
        d   = clamp(es - m_prev, -128, 127);
        pid = es * 3 + d * 7 + it;
        adj = clamp(pid >>> 3, -2048, 2047);
        el  = clamp(fw + adj, -2048, 2047);
        er  = clamp(fw - adj, -2048, 2047);
        m_prev = es;
    endtask

    // Called at a falling edge; observes ncyc cycles after the capture edge.
    task automatic sample(input int e, input int fw, input int it, input int ncyc, input int ovr_at, input int drop_at);
        error = 16'(e); frwrd_spd = 11'(fw); I_term = 10'(it); error_vld = 1'b1; go = 1'b1;
        @(posedge clk); @(negedge clk);
        obs_evld0 = err_vld; obs_err_sat = err_sat; obs_busy = '0; obs_busy[0] = busy;
        obs_lat = -1; obs_vld_cnt = 0; obs_evld_cnt = 0; obs_ovr_cnt = 0;
        error = 16'($urandom);
        error_vld = (ovr_at == 1); go = (drop_at != 1);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); @(negedge clk);
            if (pid_vld) begin obs_vld_cnt++; if (obs_lat < 0) obs_lat = k; end
            obs_evld_cnt += int'(err_vld);
            obs_ovr_cnt  += int'(ovr);
            obs_busy[k] = busy;
            error_vld = (ovr_at == k + 1); go = (drop_at != k + 1);
        end
        error_vld = 1'b0; go = 1'b1;
    endtask

    task automatic clear_prev();
        go = 1'b0; @(negedge clk); go = 1'b1; m_prev = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; go = 1'b0; error_vld = 1'b0; error = '0; frwrd_spd = '0; I_term = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (err_sat !== 11'd0) begin errors++; $display("FAIL reset_err_sat got %0d want 0", err_sat); end
        vectors++; if (lft_spd !== 12'd0 || rght_spd !== 12'd0) begin errors++; $display("FAIL reset_spd got %0d/%0d want 0/0", lft_spd, rght_spd); end
        vectors++; if ({err_vld, pid_vld, busy, ovr} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {err_vld, pid_vld, busy, ovr}); end
        rst_n = 1'b1; go = 1'b1; m_prev = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        clear_prev();
        sample(100, 400, 0, 6, 0, 0); m_prev = 100;
        vectors++; if (obs_evld0 !== 1'b1 || obs_evld_cnt != 0) begin errors++; $display("FAIL t1_err_vld got first=%b extra=%0d want 1/0", obs_evld0, obs_evld_cnt); end
        vectors++; if (obs_lat != 3 || obs_vld_cnt != 1) begin errors++; $display("FAIL t1_latency got lat=%0d cnt=%0d want 3/1", obs_lat, obs_vld_cnt); end
        vectors++; if (lft_spd !== 12'd525 || rght_spd !== 12'd275) begin errors++; $display("FAIL t1_spd got %0d/%0d want 525/275", lft_spd, rght_spd); end
        vectors++; if (obs_err_sat !== 11'd100) begin errors++; $display("FAIL t1_err_sat got %0d want 100", obs_err_sat); end
        sample(100, 400, 0, 6, 0, 0); m_prev = 100;
        vectors++; if (lft_spd !== 12'd437 || rght_spd !== 12'd363) begin errors++; $display("FAIL t2_spd got %0d/%0d want 437/363", lft_spd, rght_spd); end
        clear_prev();
        sample(2048, 2000, 0, 6, 0, 0);
        vectors++; if (obs_err_sat !== 11'h3FF) begin errors++; $display("FAIL t3_err_sat got %h want 3ff", obs_err_sat); end
        vectors++; if (lft_spd !== 12'd2047 || rght_spd !== 12'd1506) begin errors++; $display("FAIL t3_spd got %0d/%0d want 2047/1506", lft_spd, rght_spd); end
        clear_prev();
        sample(-5000, 400, 0, 6, 0, 0);
        vectors++; if (obs_err_sat !== 11'h400) begin errors++; $display("FAIL t4_err_sat got %h want 400", obs_err_sat); end
        vectors++; if (lft_spd !== 12'(-96) || rght_spd !== 12'd896) begin errors++; $display("FAIL t4_neg_spd got %0d/%0d want -96/896", $signed(lft_spd), rght_spd); end
        clear_prev();
        sample(-500, 400, 0, 6, 0, 0);
        sample(500, 400, 0, 6, 0, 0); m_prev = 500;
        vectors++; if (lft_spd !== 12'd698 || rght_spd !== 12'd102) begin errors++; $display("FAIL t4_dclamp got %0d/%0d want 698/102", lft_spd, rght_spd); end
    endtask

    task automatic test_ovr();
        clear_prev();
        sample(100, 400, 0, 6, 1, 0); m_prev = 100;
        vectors++; if (obs_ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", obs_ovr_cnt); end
        vectors++; if (obs_vld_cnt != 1 || obs_lat != 3) begin errors++; $display("FAIL ovr_pid_vld got cnt=%0d lat=%0d want 1/3", obs_vld_cnt, obs_lat); end
        vectors++; if (lft_spd !== 12'd525 || rght_spd !== 12'd275) begin errors++; $display("FAIL ovr_spd got %0d/%0d want 525/275", lft_spd, rght_spd); end
        go = 1'b0; error_vld = 1'b1;
        @(negedge clk);
        error_vld = 1'b0; m_prev = 0;
        vectors++; if (ovr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_nogo got ovr=%b busy=%b want 0/0", ovr, busy); end
        go = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        clear_prev();
        sample(300, 400, 0, 6, 0, 0);
        sample(200, 500, 0, 6, 0, 2); m_prev = 0;
        vectors++; if (obs_busy[2] !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b want 0", obs_busy[2]); end
        vectors++; if (obs_vld_cnt != 0) begin errors++; $display("FAIL abort_pid_vld got %0d want 0", obs_vld_cnt); end
        vectors++; if (lft_spd !== 12'd0 || rght_spd !== 12'd0) begin errors++; $display("FAIL abort_spd got %0d/%0d want 0/0", lft_spd, rght_spd); end
        vectors++; if (err_sat !== 11'd200) begin errors++; $display("FAIL abort_err_hold got %0d want 200", err_sat); end
        sample(100, 400, 0, 6, 0, 0); m_prev = 100;
        vectors++; if (lft_spd !== 12'd525 || rght_spd !== 12'd275) begin errors++; $display("FAIL abort_prev0 got %0d/%0d want 525/275", lft_spd, rght_spd); end
    endtask

    task automatic test_back_to_back();
        int es, el, er, e, fw, it;
        logic signed [9:0] r;
        clear_prev();
        for (int n = 0; n < 6; n++) begin
            e = $urandom_range(0, 1400) - 700; fw = $urandom_range(0, 2047); r = 10'($urandom); it = r;
            model(e, fw, it, es, el, er);
            sample(e, fw, it, 3, 0, 0);
            vectors++; if (obs_lat != 3 || obs_vld_cnt != 1) begin errors++; $display("FAIL b2b_latency n=%0d got lat=%0d cnt=%0d want 3/1", n, obs_lat, obs_vld_cnt); end
            vectors++; if (lft_spd !== 12'(el) || rght_spd !== 12'(er)) begin errors++; $display("FAIL b2b_spd n=%0d got %0d/%0d want %0d/%0d", n, $signed(lft_spd), $signed(rght_spd), el, er); end
        end
    endtask

    task automatic test_random();
        int es, el, er, e, fw, it;
        logic signed [15:0] r16;
        logic signed [9:0]  r10;
        for (int n = 0; n < 40; n++) begin
            r16 = 16'($urandom); r10 = 10'($urandom);
            e  = (n % 3 == 0) ? int'(r16) : $urandom_range(0, 2400) - 1200;
            fw = $urandom_range(0, 2047); it = r10;
            model(e, fw, it, es, el, er);
            sample(e, fw, it, 4, 0, 0);
            vectors++; if (obs_err_sat !== 11'(es)) begin errors++; $display("FAIL rnd_err_sat n=%0d got %0d want %0d", n, $signed(obs_err_sat), es); end
            vectors++; if (lft_spd !== 12'(el)) begin errors++; $display("FAIL rnd_lft n=%0d got %0d want %0d", n, $signed(lft_spd), el); end
            vectors++; if (rght_spd !== 12'(er)) begin errors++; $display("FAIL rnd_rght n=%0d got %0d want %0d", n, $signed(rght_spd), er); end
        end
    endtask

    task automatic test_reset_mid();
        error = 16'sd321; frwrd_spd = 11'd900; error_vld = 1'b1; go = 1'b1;
        @(posedge clk); @(negedge clk);
        error_vld = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0; #1;
        vectors++; if (busy !== 1'b0 || err_vld !== 1'b0 || pid_vld !== 1'b0) begin errors++; $display("FAIL midrst_strobes got busy=%b err_vld=%b pid_vld=%b want 0", busy, err_vld, pid_vld); end
        vectors++; if (err_sat !== 11'd0 || lft_spd !== 12'd0 || rght_spd !== 12'd0) begin errors++; $display("FAIL midrst_regs got %0d/%0d/%0d want 0", err_sat, lft_spd, rght_spd); end
        @(negedge clk); rst_n = 1'b1; m_prev = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovr();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
